sram_port_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single generic SRAM bank. It sits between the instruction-fetch and data request ports and the SRAM bank pins. It grants one access per cycle, with bounded-starvation priority for data. It drives a registered command stage into the bank and returns read data to the correct requester after the bank's fixed read latency. It replaces duplicate per-master SRAM paths with one shared, deterministic access point.

---
 rtl/sram_arb_pkg.sv | 33 +++
 rtl/sram_arb_resp_pipe.sv | 39 +++
 rtl/sram_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared types and constants for the two-port SRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    // Requester indices into the per-port request/grant vectors
    localparam int PORT_IMEM = 0;
    localparam int PORT_DMEM = 1;

    // Default geometry of the bank
    localparam int c_addr_width = 12;
    localparam int c_data_width = 32;
    localparam int c_be_width   = c_data_width / 8;

    // One access request as presented by a requester
    typedef struct packed {
        logic [c_addr_width-1:0] addr;
        logic                    we;
        logic [c_be_width-1:0]   be;
        logic [c_data_width-1:0] wdata;
    } sram_req_t;

    // Tag travelling alongside an outstanding read
    typedef struct packed {
        logic valid;
        logic port;
    } resp_tag_t;

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/sram_arb_resp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_resp_pipe
// Description : Fixed-depth shift register of read tags covering the bank's
//               read latency; cleared asynchronously so that reads in flight
//               at reset never produce a response.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arb_resp_pipe
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  resp_tag_t i_tag,
    output resp_tag_t o_tag
);

    resp_tag_t r_stage [DEPTH];

    // Advance every tag one stage per cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule : sram_arb_resp_pipe
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter
// Description : Grants one of two requesters (instruction / data) access to a
//               single SRAM bank per cycle, data port first with a bounded
//               starvation window for the instruction port. Drives a
//               registered command stage and routes read data back to the
//               requester after the bank's read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2,
    parameter int BURST_LIMIT  = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [1:0]                i_req,
    output logic [1:0]                o_gnt,
    input  logic [2*ADDR_WIDTH-1:0]   i_addr,
    input  logic [1:0]                i_we,
    input  logic [2*DATA_WIDTH/8-1:0] i_be,
    input  logic [2*DATA_WIDTH-1:0]   i_wdata,
    output logic [1:0]                o_rvalid,
    output logic [DATA_WIDTH-1:0]     o_rdata,
    output logic                      o_mem_ce,
    output logic                      o_mem_we,
    output logic [DATA_WIDTH/8-1:0]   o_mem_be,
    output logic [ADDR_WIDTH-1:0]     o_mem_addr,
    output logic [DATA_WIDTH-1:0]     o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]     i_mem_rdata
);

    localparam int                     c_be_width  = DATA_WIDTH / 8;
    localparam int                     c_cnt_width = $clog2(BURST_LIMIT + 1);
    localparam logic [c_cnt_width-1:0] c_burst_max = c_cnt_width'(BURST_LIMIT);

    logic [c_cnt_width-1:0] r_burst_cnt;
    logic                   w_at_limit;
    logic [1:0]             w_gnt;
    logic                   w_xfer;
    logic                   w_sel;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic                   w_sel_we;
    logic [c_be_width-1:0]  w_sel_be;
    logic [DATA_WIDTH-1:0]  w_sel_wdata;
    logic                   r_port;
    resp_tag_t              w_push_tag;
    resp_tag_t              w_pipe_tag;
    logic [1:0]             r_rvalid;

    assign w_at_limit = (r_burst_cnt == c_burst_max);

    // Data port wins unless the instruction port has waited out its window
    always_comb begin
        w_gnt = 2'b00;
        if (i_rst_n) begin
            if (i_req[PORT_IMEM] && (!i_req[PORT_DMEM] || w_at_limit)) begin
                w_gnt[PORT_IMEM] = 1'b1;
            end else if (i_req[PORT_DMEM]) begin
                w_gnt[PORT_DMEM] = 1'b1;
            end
        end
    end

    assign o_gnt  = w_gnt;
    assign w_xfer = |w_gnt;
    assign w_sel  = w_gnt[PORT_DMEM];

    // Fields of whichever port holds the grant
    assign w_sel_addr  = w_sel ? i_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]  : i_addr[ADDR_WIDTH-1:0];
    assign w_sel_we    = w_sel ? i_we[1]                            : i_we[0];
    assign w_sel_be    = w_sel ? i_be[2*c_be_width-1:c_be_width]    : i_be[c_be_width-1:0];
    assign w_sel_wdata = w_sel ? i_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : i_wdata[DATA_WIDTH-1:0];

    // Count data-port wins while the instruction port is kept waiting
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_burst_cnt <= '0;
        end else if (!i_req[PORT_IMEM] || w_gnt[PORT_IMEM]) begin
            r_burst_cnt <= '0;
        end else if (w_gnt[PORT_DMEM] && !w_at_limit) begin
            r_burst_cnt <= r_burst_cnt + c_cnt_width'(1);
        end
    end

    // Register the granted access onto the bank pins; idle cycles deassert
    // the strobes but leave address and write data where they were
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem_ce    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_be    <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            r_port      <= 1'b0;
        end else if (w_xfer) begin
            o_mem_ce    <= 1'b1;
            o_mem_we    <= w_sel_we;
            o_mem_be    <= w_sel_be;
            o_mem_addr  <= w_sel_addr;
            o_mem_wdata <= w_sel_wdata;
            r_port      <= w_sel;
        end else begin
            o_mem_ce    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_be    <= '0;
        end
    end

    // A read leaves the command stage as the bank samples it
    assign w_push_tag.valid = o_mem_ce & ~o_mem_we;
    assign w_push_tag.port  = r_port;

    sram_arb_resp_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_resp_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_tag   (w_push_tag),
        .o_tag   (w_pipe_tag)
    );

    // The bank drives its data READ_LATENCY cycles after sampling, which is
    // one cycle past the tag reaching the end of the pipe; align the strobe
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rvalid <= 2'b00;
        end else begin
            r_rvalid <= 2'b00;
            if (w_pipe_tag.valid) begin
                r_rvalid[w_pipe_tag.port] <= 1'b1;
            end
        end
    end

    assign o_rvalid = r_rvalid;
    assign o_rdata  = i_mem_rdata;

endmodule : sram_port_arbiter
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_port_arbiter
// Description : Self-checking bench: directed scenarios plus randomized
//               traffic against a transaction-level reference model and a
//               behavioural SRAM bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int RL = 2;
    localparam int BL = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req;
    logic [1:0]      gnt;
    logic [2*AW-1:0] addr;
    logic [1:0]      we;
    logic [2*BW-1:0] be;
    logic [2*DW-1:0] wdata;
    logic [1:0]      rvalid;
    logic [DW-1:0]   rdata;
    logic            mem_ce;
    logic            mem_we;
    logic [BW-1:0]   mem_be;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (RL),
        .BURST_LIMIT  (BL)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .o_gnt       (gnt),
        .i_addr      (addr),
        .i_we        (we),
        .i_be        (be),
        .i_wdata     (wdata),
        .o_rvalid    (rvalid),
        .o_rdata     (rdata),
        .o_mem_ce    (mem_ce),
        .o_mem_we    (mem_we),
        .o_mem_be    (mem_be),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    typedef struct {
        int          due;
        int          port;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } bank_t;

    logic [DW-1:0] shadow [4096];
    logic [DW-1:0] bank   [4096];
    exp_t          sb[$];
    bank_t         bq[$];
    int            wins;
    int            edge_no;
    int            last_xfer;
    int            rv_seen;
    logic [1:0]    last_gnt;
    logic [DW-1:0] seen_rdata;
    logic [15:0]   gseq;
    int            n_checks;
    int            n_fail;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    // Who should win this cycle, from the arbitration rules alone
    function automatic logic [1:0] model_grant(input logic r, input logic [1:0] q, input int w);
        if (!r)              return 2'b00;
        if (q == 2'b11)      return (w >= BL) ? 2'b01 : 2'b10;
        if (q[1])            return 2'b10;
        if (q[0])            return 2'b01;
        return 2'b00;
    endfunction

    task automatic set_port(input int p, input logic r, input logic [AW-1:0] a,
                            input logic w, input logic [BW-1:0] b, input logic [DW-1:0] d);
        sram_req_t c;
        c.addr  = a;
        c.we    = w;
        c.be    = b;
        c.wdata = d;
        req[p]            = r;
        addr[p*AW +: AW]  = c.addr;
        we[p]             = c.we;
        be[p*BW +: BW]    = c.be;
        wdata[p*DW +: DW] = c.wdata;
    endtask

    // One clock cycle: check at the falling edge, then advance model and bank
    task automatic step(input bit assert_rst, input bit release_rst);
        logic [1:0]    exp_g;
        logic [1:0]    exp_rv;
        logic [DW-1:0] exp_d;
        logic          c_ce, c_we;
        logic [BW-1:0] c_be;
        logic [AW-1:0] c_addr, a;
        logic [DW-1:0] c_wd, d;
        logic [BW-1:0] b;
        int            p;

        @(negedge clk);
        exp_g = model_grant(rst_n, req, wins);
        check_eq("gnt", {62'd0, gnt}, {62'd0, exp_g});
        exp_rv = 2'b00;
        exp_d  = '0;
        if (sb.size() != 0 && sb[0].due == edge_no) begin
            exp_rv[sb[0].port] = 1'b1;
            exp_d = sb[0].data;
            void'(sb.pop_front());
        end
        check_eq("rvalid", {62'd0, rvalid}, {62'd0, exp_rv});
        if (exp_rv != 2'b00) check_eq("rdata", {32'd0, rdata}, {32'd0, exp_d});
        if (rvalid != 2'b00) begin
            seen_rdata = rdata;
            rv_seen++;
        end
        check_eq("mem_ce", {63'd0, mem_ce}, {63'd0, (rst_n === 1'b1 && last_xfer == edge_no)});
        if (!rst_n) check_eq("mem_pins_in_reset", {15'd0, mem_we, mem_be, mem_addr, mem_wdata}, 64'd0);
        gseq = {gseq[13:0], gnt};

        if (assert_rst) begin
            rst_n = 1'b0;
            sb.delete();
            wins      = 0;
            last_xfer = -100;
        end
        if (release_rst) rst_n = 1'b1;
        #1;
        exp_g    = model_grant(rst_n, req, wins);
        last_gnt = exp_g;
        c_ce   = mem_ce;
        c_we   = mem_we;
        c_be   = mem_be;
        c_addr = mem_addr;
        c_wd   = mem_wdata;

        @(posedge clk);
        edge_no++;
        if (exp_g != 2'b00) begin
            p = exp_g[1] ? 1 : 0;
            a = addr[p*AW +: AW];
            b = be[p*BW +: BW];
            d = wdata[p*DW +: DW];
            if (we[p]) begin
                for (int k = 0; k < BW; k++) if (b[k]) shadow[a][8*k +: 8] = d[8*k +: 8];
            end else begin
                sb.push_back('{edge_no + 1 + RL, p, shadow[a]});
            end
            last_xfer = edge_no;
        end
        if (rst_n) begin
            if (!req[0] || exp_g == 2'b01) wins = 0;
            else if (exp_g == 2'b10 && wins < BL) wins++;
        end
        if (c_ce) begin
            if (c_we) begin
                for (int k = 0; k < BW; k++) if (c_be[k]) bank[c_addr][8*k +: 8] = c_wd[8*k +: 8];
            end else begin
                bq.push_back('{edge_no + RL, bank[c_addr]});
            end
        end
        #1;
        if (bq.size() != 0 && bq[0].due == edge_no) begin
            mem_rdata = bq[0].data;
            void'(bq.pop_front());
        end else begin
            mem_rdata = $urandom;
        end
    endtask

    initial begin
        int rv_before;
        n_checks   = 0;
        n_fail     = 0;
        wins       = 0;
        edge_no    = 0;
        last_xfer  = -100;
        rv_seen    = 0;
        last_gnt   = 2'b00;
        seen_rdata = '0;
        gseq       = '0;
        rst_n      = 1'b1;
        req        = '0;
        addr       = '0;
        we         = '0;
        be         = '0;
        wdata      = '0;
        mem_rdata  = '0;
        for (int i = 0; i < 4096; i++) begin
            shadow[i] = 32'(i) * 32'h9E37_79B1;
            bank[i]   = shadow[i];
        end
        shadow[12'h010] = 32'hDEAD_BEEF; bank[12'h010] = 32'hDEAD_BEEF;
        shadow[12'h020] = 32'hAAAA_AAAA; bank[12'h020] = 32'hAAAA_AAAA;
        #2 rst_n = 1'b0;

        // Reset state, then release
        repeat (3) step(0, 0);
        step(0, 1);

        // Idle cycles
        repeat (5) step(0, 0);

        // Single read from the instruction port
        seen_rdata = '0;
        set_port(0, 1'b1, 12'h010, 1'b0, 4'hF, 32'd0);
        step(0, 0);
        set_port(0, 1'b0, 12'h010, 1'b0, 4'hF, 32'd0);
        repeat (5) step(0, 0);
        check_eq("single_read_data", {32'd0, seen_rdata}, {32'd0, 32'hDEAD_BEEF});

        // Both ports request continuously
        set_port(0, 1'b1, 12'h040, 1'b0, 4'hF, 32'd0);
        set_port(1, 1'b1, 12'h050, 1'b0, 4'hF, 32'd0);
        gseq = '0;
        repeat (8) step(0, 0);
        check_eq("burst_grant_seq", {48'd0, gseq}, {48'd0, 16'b10_10_10_01_10_10_10_01});
        req = 2'b00;
        repeat (6) step(0, 0);

        // Partial write then read-back on the data port
        set_port(1, 1'b1, 12'h020, 1'b1, 4'b0011, 32'h1234_5678);
        step(0, 0);
        set_port(1, 1'b1, 12'h020, 1'b0, 4'hF, 32'd0);
        step(0, 0);
        req = 2'b00;
        seen_rdata = '0;
        repeat (5) step(0, 0);
        check_eq("write_then_read", {32'd0, seen_rdata}, {32'd0, 32'hAAAA_5678});

        // Reset with two reads in flight
        rv_before = rv_seen;
        set_port(0, 1'b1, 12'h010, 1'b0, 4'hF, 32'd0);
        step(0, 0);
        set_port(0, 1'b1, 12'h011, 1'b0, 4'hF, 32'd0);
        step(0, 0);
        req = 2'b00;
        step(1, 0);
        step(0, 0);
        step(0, 1);
        repeat (5) step(0, 0);
        check_eq("reset_drops_reads", 64'(rv_seen - rv_before), 64'd0);

        // Instruction port drops its request mid-window
        set_port(0, 1'b1, 12'h060, 1'b0, 4'hF, 32'd0);
        set_port(1, 1'b1, 12'h070, 1'b0, 4'hF, 32'd0);
        repeat (2) step(0, 0);
        req[0] = 1'b0;
        step(0, 0);
        req[0] = 1'b1;
        gseq = '0;
        repeat (4) step(0, 0);
        check_eq("port0_drop_seq", {56'd0, gseq[7:0]}, {56'd0, 8'b10_10_10_01});
        req = 2'b00;
        repeat (6) step(0, 0);

        // Randomized traffic; a waiting requester holds its request
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(req[p] && !last_gnt[p])) begin
                    set_port(p, ($urandom_range(0, 3) != 0),
                             AW'($urandom_range(0, 31)),
                             1'($urandom_range(0, 1)),
                             BW'($urandom),
                             $urandom);
                end
            end
            step(0, 0);
        end
        req = 2'b00;
        repeat (8) step(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sram_port_arbiter
`default_nettype wire
